// File: rtl/subtract_arbiter.sv
// Round-robin sharing of one I/Q subtractor between two request channels.
// Tags ride a latency-matched pipeline; results are returned through held response ports.
module subtract_arbiter #(
    parameter int unsigned SUB_LATENCY = 1,
    parameter int unsigned HOLDOFF     = 2
) (
    input  logic        M100CLK,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [31:0] req0_i,
    input  logic [31:0] req1_i,
    input  logic [31:0] req0_q,
    input  logic [31:0] req1_q,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    input  logic        rsp0_ready,
    input  logic        rsp1_ready,
    output logic [31:0] rsp0_data,
    output logic [31:0] rsp1_data,
    output logic [31:0] sub_i,
    output logic [31:0] sub_q,
    input  logic [31:0] sub_sum,
    output logic        busy
);

    localparam int unsigned TagDepth = SUB_LATENCY + 1;
    localparam int unsigned HoldW    = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StHold
    } ch_state_e;

    typedef struct packed {
        logic vld;
        logic ch;
    } tag_t;

    logic [1:0]       req_valid;
    logic [1:0]       rsp_ready;
    logic [HoldW-1:0] hold_cnt_q;
    logic [HoldW-1:0] hold_cnt_d;
    logic             hold_done;
    ch_state_e        state_q [2];
    ch_state_e        state_d [2];
    logic [1:0]       elig;
    logic             grant_vld;
    logic             grant_ch;
    logic             last_grant_q;
    tag_t             tag_q [TagDepth];
    tag_t             tag_exit;
    logic [1:0]       capture;
    logic [1:0]       consume;
    logic [1:0]       rsp_valid_q;
    logic [31:0]      rsp_data_q [2];
    logic [31:0]      sub_i_q;
    logic [31:0]      sub_q_q;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    // Holdoff masks grants while the subtractor's own registered reset settles.
    assign hold_done = (hold_cnt_q == '0);

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (!hold_done) begin
            hold_cnt_d = hold_cnt_q - HoldW'(1);
        end
    end

    always_ff @(posedge M100CLK or posedge reset) begin
        if (reset) begin
            hold_cnt_q <= HoldW'(HOLDOFF);
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign elig[0] = req_valid[0] && (state_q[0] == StIdle) && hold_done;
    assign elig[1] = req_valid[1] && (state_q[1] == StIdle) && hold_done;

    always_comb begin
        grant_vld = |elig;
        grant_ch  = elig[1];
        if (&elig) begin
            grant_ch = ~last_grant_q;
        end
    end

    assign req0_ready = grant_vld & ~grant_ch;
    assign req1_ready = grant_vld & grant_ch;

    always_ff @(posedge M100CLK or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (grant_vld) begin
            last_grant_q <= grant_ch;
        end
    end

    always_ff @(posedge M100CLK or posedge reset) begin
        if (reset) begin
            sub_i_q <= '0;
            sub_q_q <= '0;
        end else if (grant_vld) begin
            sub_i_q <= grant_ch ? req1_i : req0_i;
            sub_q_q <= grant_ch ? req1_q : req0_q;
        end
    end

    assign sub_i = sub_i_q;
    assign sub_q = sub_q_q;

    // The last stage lines up with the cycle in which sub_sum holds this tag's result.
    assign tag_exit = tag_q[SUB_LATENCY];

    always_ff @(posedge M100CLK or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < TagDepth; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= '{vld: grant_vld, ch: grant_ch};
            for (int k = 1; k < TagDepth; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        capture = '0;
        consume = '0;
        for (int n = 0; n < 2; n++) begin
            unique case (state_q[n])
                StIdle: begin
                    if (grant_vld && (grant_ch == 1'(n))) begin
                        state_d[n] = StWait;
                    end
                end
                StWait: begin
                    if (tag_exit.vld && (tag_exit.ch == 1'(n))) begin
                        state_d[n] = StHold;
                        capture[n] = 1'b1;
                    end
                end
                StHold: begin
                    if (rsp_ready[n]) begin
                        state_d[n] = StIdle;
                        consume[n] = 1'b1;
                    end
                end
                default: state_d[n] = StIdle;
            endcase
        end
    end

    always_ff @(posedge M100CLK or posedge reset) begin
        if (reset) begin
            state_q[0] <= StIdle;
            state_q[1] <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge M100CLK or posedge reset) begin
        if (reset) begin
            rsp_valid_q   <= '0;
            rsp_data_q[0] <= '0;
            rsp_data_q[1] <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (capture[n]) begin
                    rsp_valid_q[n] <= 1'b1;
                    rsp_data_q[n]  <= sub_sum;
                end else if (consume[n]) begin
                    rsp_valid_q[n] <= 1'b0;
                end
            end
        end
    end

    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp0_data  = rsp_data_q[0];
    assign rsp1_data  = rsp_data_q[1];

    assign busy = !hold_done || (state_q[0] != StIdle) || (state_q[1] != StIdle);

    a_no_grant_in_holdoff: assert property (@(posedge M100CLK) disable iff (reset)
        !hold_done |-> !grant_vld);

    a_exit_hits_waiting: assert property (@(posedge M100CLK) disable iff (reset)
        tag_exit.vld |-> (state_q[tag_exit.ch] == StWait));

    a_rsp0_tracks_hold: assert property (@(posedge M100CLK) disable iff (reset)
        rsp_valid_q[0] == (state_q[0] == StHold));

    a_rsp1_tracks_hold: assert property (@(posedge M100CLK) disable iff (reset)
        rsp_valid_q[1] == (state_q[1] == StHold));

endmodule

// File: tb/tb_subtract_arbiter.sv
// Randomised and directed bench for subtract_arbiter against a cycle-level behavioural model.
module tb_subtract_arbiter;

    localparam int HOLDOFF = 2;
    localparam int LAT     = 3;  // handshake to rsp_valid at SUB_LATENCY = 1

    logic        M100CLK;
    logic        reset;
    logic        tb_v  [2];
    logic        tb_rr [2];
    logic [31:0] tb_i  [2];
    logic [31:0] tb_q  [2];
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
    logic [31:0] rsp0_data, rsp1_data, sub_i, sub_q, sub_sum;
    logic [32:0] sub_diff;

    subtract_arbiter #(.SUB_LATENCY(1), .HOLDOFF(HOLDOFF)) dut (
        .M100CLK   (M100CLK),
        .reset     (reset),
        .req0_valid(tb_v[0]),
        .req1_valid(tb_v[1]),
        .req0_ready(req0_ready),
        .req1_ready(req1_ready),
        .req0_i    (tb_i[0]),
        .req1_i    (tb_i[1]),
        .req0_q    (tb_q[0]),
        .req1_q    (tb_q[1]),
        .rsp0_valid(rsp0_valid),
        .rsp1_valid(rsp1_valid),
        .rsp0_ready(tb_rr[0]),
        .rsp1_ready(tb_rr[1]),
        .rsp0_data (rsp0_data),
        .rsp1_data (rsp1_data),
        .sub_i     (sub_i),
        .sub_q     (sub_q),
        .sub_sum   (sub_sum),
        .busy      (busy)
    );

    // Single-cycle I/Q subtractor with registered reset.
    assign sub_diff = {sub_i[31], sub_i} - {sub_q[31], sub_q};
    always_ff @(posedge M100CLK or posedge reset) begin
        if (reset) sub_sum <= '0;
        else       sub_sum <= sub_diff[32:1];
    end

    initial M100CLK = 1'b0;
    always #5 M100CLK = ~M100CLK;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          rel_cyc = 0;
    logic        pend [2];
    int          hs_cyc [2];
    logic [31:0] exp_data [2];
    logic        last_g;
    logic [31:0] m_sub_i, m_sub_q;
    logic        obs_ready [2];
    logic        obs_rvalid [2];
    logic [31:0] obs_rdata [2];
    logic        hs [2];
    int          mode [2];  // 0: drop valid after handshake, 1: re-arm, 2: random
    logic        rand_rr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] half_diff(input logic [31:0] a, input logic [31:0] b);
        longint d;
        d = longint'($signed(a)) - longint'($signed(b));
        d = d >>> 1;
        return d[31:0];
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0000;
            default: return $urandom();
        endcase
    endfunction

    task automatic new_ops(input int n);
        tb_i[n] = rand_word();
        tb_q[n] = rand_word();
    endtask

    // One clock cycle: sample at negedge, compare with the model, advance it, then drive.
    task automatic step();
        logic hold_ok;
        logic elig [2];
        logic exp_rv [2];
        int   g;
        @(negedge M100CLK);
        obs_ready[0]  = req0_ready;  obs_ready[1]  = req1_ready;
        obs_rvalid[0] = rsp0_valid;  obs_rvalid[1] = rsp1_valid;
        obs_rdata[0]  = rsp0_data;   obs_rdata[1]  = rsp1_data;
        hold_ok = (rel_cyc >= HOLDOFF);
        for (int n = 0; n < 2; n++) begin
            elig[n]   = tb_v[n] && !pend[n] && hold_ok;
            exp_rv[n] = pend[n] && (cyc - hs_cyc[n] >= LAT);
        end
        g = -1;
        if (elig[0] && elig[1]) g = last_g ? 0 : 1;
        else if (elig[0])       g = 0;
        else if (elig[1])       g = 1;
        for (int n = 0; n < 2; n++) begin
            check($sformatf("ready%0d", n), 32'(obs_ready[n]), 32'(g == n));
            check($sformatf("rsp_valid%0d", n), 32'(obs_rvalid[n]), 32'(exp_rv[n]));
            if (exp_rv[n]) check($sformatf("rsp_data%0d", n), obs_rdata[n], exp_data[n]);
        end
        check("busy", 32'(busy), 32'(!hold_ok || pend[0] || pend[1]));
        check("sub_i", sub_i, m_sub_i);
        check("sub_q", sub_q, m_sub_q);
        for (int n = 0; n < 2; n++) begin
            if (exp_rv[n] && tb_rr[n]) pend[n] = 1'b0;
            hs[n] = tb_v[n] && obs_ready[n];
        end
        if (g >= 0) begin
            pend[g]     = 1'b1;
            hs_cyc[g]   = cyc;
            exp_data[g] = half_diff(tb_i[g], tb_q[g]);
            m_sub_i     = tb_i[g];
            m_sub_q     = tb_q[g];
            last_g      = (g == 1);
        end
        cyc++;
        rel_cyc++;
        @(posedge M100CLK);
        #1;
        for (int n = 0; n < 2; n++) begin
            if (mode[n] == 0 && hs[n]) tb_v[n] = 1'b0;
            else if (mode[n] == 1 && hs[n]) new_ops(n);
            else if (mode[n] == 2 && (hs[n] || !tb_v[n])) begin
                tb_v[n] = ($urandom_range(0, 2) != 0);
                new_ops(n);
            end
            if (rand_rr) tb_rr[n] = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        check("rst_rsp0_data", rsp0_data, 32'd0);
        check("rst_rsp1_data", rsp1_data, 32'd0);
        check("rst_sub_i", sub_i, 32'd0);
        check("rst_sub_q", sub_q, 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
        repeat (2) @(posedge M100CLK);
        #1;
        reset   = 1'b0;
        rel_cyc = 0;
        pend[0] = 1'b0;  pend[1] = 1'b0;
        hs[0]   = 1'b0;  hs[1]   = 1'b0;
        last_g  = 1'b1;
        m_sub_i = '0;
        m_sub_q = '0;
    endtask

    initial begin
        int first_rdy, first_rv, npulse, g0, g1, r0, r1, prev, cnt, ch1_done, found;
        logic [31:0] d0, d1, held;
        reset = 1'b0;
        rand_rr = 1'b0;
        for (int n = 0; n < 2; n++) begin
            tb_v[n] = 1'b0; tb_rr[n] = 1'b1; tb_i[n] = '0; tb_q[n] = '0;
            mode[n] = 0; pend[n] = 1'b0; hs_cyc[n] = 0; exp_data[n] = '0;
        end
        #2;

        // Holdoff and latency
        tb_v[0] = 1'b1; tb_i[0] = 32'd10; tb_q[0] = 32'd4;
        do_reset();
        first_rdy = -1; first_rv = -1; npulse = 0; d0 = '0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (obs_ready[0]) begin
                npulse++;
                if (first_rdy < 0) first_rdy = k;
            end
            if (obs_rvalid[0] && first_rv < 0) begin
                first_rv = k; d0 = obs_rdata[0];
            end
        end
        check("t1_grant_cycle", 32'(first_rdy), 32'd2);
        check("t1_ready_pulses", 32'(npulse), 32'd1);
        check("t1_rsp_cycle", 32'(first_rv), 32'd5);
        check("t1_rsp_data", d0, 32'd3);

        // Two channels, sign and overflow
        tb_v[0] = 1'b1; tb_i[0] = 32'hFFFF_FFFB; tb_q[0] = 32'd3;
        tb_v[1] = 1'b1; tb_i[1] = 32'h7FFF_FFFF; tb_q[1] = 32'h8000_0000;
        do_reset();
        g0 = -1; g1 = -1; r0 = -1; r1 = -1; d0 = '0; d1 = '0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (obs_ready[0] && g0 < 0) g0 = k;
            if (obs_ready[1] && g1 < 0) g1 = k;
            if (obs_rvalid[0] && r0 < 0) begin r0 = k; d0 = obs_rdata[0]; end
            if (obs_rvalid[1] && r1 < 0) begin r1 = k; d1 = obs_rdata[1]; end
        end
        check("t2_grant0_cycle", 32'(g0), 32'd2);
        check("t2_grant1_cycle", 32'(g1), 32'd3);
        check("t2_rsp0_data", d0, 32'hFFFF_FFFC);
        check("t2_rsp1_data", d1, 32'h7FFF_FFFF);
        check("t2_rsp_gap", 32'(r1 - r0), 32'd1);

        // Back-pressure on channel 0
        mode[0] = 1; mode[1] = 1;
        tb_rr[0] = 1'b0; tb_rr[1] = 1'b1;
        tb_v[0] = 1'b1; new_ops(0);
        tb_v[1] = 1'b1; new_ops(1);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            step();
            if (obs_rvalid[0]) found = 1;
        end
        check("t3_rsp0_seen", 32'(found), 32'd1);
        held = obs_rdata[0];
        ch1_done = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            check("t3_rsp0_valid_held", 32'(obs_rvalid[0]), 32'd1);
            check("t3_rsp0_data_held", obs_rdata[0], held);
            check("t3_ready0_blocked", 32'(obs_ready[0]), 32'd0);
            if (obs_rvalid[1] && tb_rr[1]) ch1_done++;
        end
        check("t3_ch1_progress", 32'(ch1_done >= 2), 32'd1);
        tb_rr[0] = 1'b1;
        mode[0] = 0;
        step();
        check("t3_consume", 32'(obs_rvalid[0]), 32'd1);
        step();
        check("t3_regrant", 32'(obs_ready[0]), 32'd1);
        mode[1] = 0;
        repeat (10) step();

        // Fairness
        mode[0] = 1; mode[1] = 1;
        tb_v[0] = 1'b1; new_ops(0);
        tb_v[1] = 1'b1; new_ops(1);
        cnt = 0; prev = -1;
        for (int k = 0; k < 200 && cnt < 20; k++) begin
            step();
            if (obs_ready[0] || obs_ready[1]) begin
                g0 = obs_ready[1] ? 1 : 0;
                if (prev >= 0) check("t4_alternate", 32'(g0 != prev), 32'd1);
                prev = g0;
                cnt++;
            end
        end
        check("t4_count", 32'(cnt), 32'd20);
        mode[0] = 0; mode[1] = 0;
        repeat (10) step();

        // Randomised traffic with random back-pressure
        mode[0] = 2; mode[1] = 2; rand_rr = 1'b1;
        repeat (600) step();
        mode[0] = 0; mode[1] = 0; rand_rr = 1'b0;
        tb_rr[0] = 1'b1; tb_rr[1] = 1'b1;
        repeat (15) step();

        // Reset while in flight
        tb_v[0] = 1'b1; tb_i[0] = 32'h1234_5678; tb_q[0] = 32'h0000_0010;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            step();
            if (obs_ready[0]) found = 1;
        end
        check("t5_handshake", 32'(found), 32'd1);
        tb_v[0] = 1'b1; tb_i[0] = 32'd100; tb_q[0] = 32'd40;
        do_reset();
        first_rdy = -1; first_rv = -1; d0 = '0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (obs_ready[0] && first_rdy < 0) first_rdy = k;
            if (obs_rvalid[0] && first_rv < 0) begin first_rv = k; d0 = obs_rdata[0]; end
        end
        check("t5_grant_cycle", 32'(first_rdy), 32'd2);
        check("t5_rsp_cycle", 32'(first_rv), 32'd5);
        check("t5_rsp_data", d0, 32'd30);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/subtract_arbiter.md
# subtract_arbiter

Shares one I/Q subtractor between two requesting channels in the DRFM datapath. Each channel hands over a 32-bit I/Q pair through a valid/ready handshake. The block schedules issues to the subtractor with round-robin arbitration and tracks in-flight operations with a tag pipeline matched to the subtractor latency. It returns each halved difference to the originating channel through a buffered, back-pressured response port.

## Interface
Parameters:
- SUB_LATENCY, 1: cycles from sub_i/sub_q visible at the subtractor to sub_sum valid.
- HOLDOFF, 2: cycles after reset release during which no request is granted.

Ports:
- M100CLK  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- req0_valid, req1_valid  in  1  channel n has a pair pending.
- req0_ready, req1_ready  out  1  channel n pair accepted this cycle.
- req0_i, req1_i  in  32  signed I operand.
- req0_q, req1_q  in  32  signed Q operand.
- rsp0_valid, rsp1_valid  out  1  result held for channel n.
- rsp0_ready, rsp1_ready  in  1  channel n consumes the result.
- rsp0_data, rsp1_data  out  32  result for channel n.
- sub_i, sub_q  out  32  registered operands to the subtractor.
- sub_sum  in  32  subtractor result.
- busy  out  1  holdoff active, or any channel not IDLE.

## Operation
- Reset values: req_ready 0, rsp_valid 0, rsp_data 0, sub_i/sub_q 0, all tags cleared, channel states IDLE, last_grant = 1, holdoff counter = HOLDOFF, busy 1.
- Holdoff: after reset release the counter decrements once per cycle. While it is nonzero, nothing is granted. This covers the subtractor's registered internal reset.
- Each channel has its own three-state FSM:
  - IDLE → WAIT on handshake (req_valid & req_ready).
  - WAIT → HOLD on the edge where that channel's tag leaves the tag pipeline. On that edge sub_sum is captured into rsp_data and rsp_valid is set.
  - HOLD → IDLE on rsp_valid & rsp_ready; rsp_valid clears on the same edge.
- Eligibility: a channel is eligible when req_valid is high, its state is IDLE, and holdoff is 0.
- Arbitration: one grant per cycle at most.
  - If one channel is eligible, it is granted.
  - If both are eligible, the channel ≠ last_grant is granted.
  - last_grant updates on every grant.
- req_ready is combinational: high only for the granted channel in the grant cycle.
- Requesters hold valid, i and q stable until ready.
- Issue: on a handshake, sub_i/sub_q load the granted operands and a tag {valid, channel} enters stage 0 of a (SUB_LATENCY+1)-deep tag shift register.
  - With no handshake, stage 0 gets valid = 0 and sub_i/sub_q hold their last values.
- Width rules: rsp_data = sub_sum captured unmodified. The subtractor returns bits [32:1] of the 33-bit signed difference i − q, which is an arithmetic halving. No saturation is applied.
- A channel is never re-granted before its previous result is consumed, so there is at most one operation in flight per channel.
- A result is never dropped or overwritten while in HOLD.
- Reset mid-operation: all in-flight tags are discarded and outputs return to reset values immediately (asynchronous). Holdoff reloads. No stale rsp_valid appears after release.

## Timing
- Handshake in cycle t: sub_i/sub_q are visible in cycle t+1, and sub_sum is valid in cycle t+1+SUB_LATENCY.
- rsp_valid rises in cycle t+SUB_LATENCY+2, which is t+3 at the defaults.
- HOLD→IDLE happens on the consuming edge. The earliest next grant for that channel is the following cycle.
- Best per-channel throughput at defaults, with rsp_ready tied high: one result every 4 cycles.
- Aggregate throughput with two channels: up to 2 results per 4 cycles.
- Simultaneous events:
  - Both channels' results are captured in different cycles, because grants are serialized.
  - A grant and a tag exit in the same cycle are independent.
- First grant possible in cycle HOLDOFF after release, counting the release cycle as 0.

## Test plan
Bench connects the team's I/Q subtractor with SUB_LATENCY=1 and uses default parameters.
1. **Holdoff and latency.** Release reset with req0_valid=1, i=10, q=4. req0_ready must stay 0 for 2 cycles, then pulse once. rsp0_valid rises 3 cycles after the handshake with rsp0_data=3.
2. **Two channels, sign and overflow.**
   - Stimulus: both valid in the same cycle. Channel 0: i=0xFFFFFFFB, q=3. Channel 1: i=0x7FFFFFFF, q=0x80000000.
   - Required: channel 0 is granted first and channel 1 in the next cycle.
   - Required: rsp0_data=0xFFFFFFFC and rsp1_data=0x7FFFFFFF, arriving one cycle apart.
3. **Back-pressure.** Hold rsp0_ready=0 for 10 cycles with req0_valid kept high.
   - rsp0_valid and rsp0_data stay stable and req0_ready stays 0.
   - Channel 1 continues to complete requests.
   - After rsp0_ready rises, channel 0 is re-granted the next cycle.
4. **Fairness.** Both channels valid continuously, rsp_ready tied high, 20 requests. Grants alternate 0,1,0,1 with no channel granted twice in a row while the other is eligible. All 20 results are correct and in order per channel.
5. **Reset while in flight.** Assert reset one cycle after a handshake.
   - rsp outputs and sub_i/sub_q go to 0 immediately and busy=1.
   - After release, no rsp_valid appears until a new request completes.
   - The holdoff of 2 cycles is re-enforced.
